// File: rtl/dtree_pkg.sv
// Field layout helpers and FSM encodings for the decision-tree traversal engine.
// Node word, MSB to LSB: reserved, child[1:0], unit one-hot, coefficients, bias.
package dtree_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EVAL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int node_width(input int f, input int cb, input int bb);
        return 3 + f + (f - 1) * cb + bb;
    endfunction

    function automatic int coeff_lsb(input int j, input int cb, input int bb);
        return bb + j * cb;
    endfunction

    function automatic int unit_lsb(input int f, input int cb, input int bb);
        return bb + (f - 1) * cb;
    endfunction

    function automatic int child_lsb(input int f, input int cb, input int bb);
        return unit_lsb(f, cb, bb) + f;
    endfunction

    // Wide enough for the worst-case sum of all terms: no overflow handling needed.
    function automatic int acc_width(input int f, input int fb, input int cb, input int bb);
        int widest;
        widest = (fb + cb > bb) ? (fb + cb) : bb;
        return widest + $clog2(f) + 2;
    endfunction

endpackage

// File: rtl/dtree_node_eval.sv
// Combinational oblique split: sum = x[unit] + sum(coeff_j * x_j) + bias, d = (sum >= 0).
// Zero latency; no flow control, the caller samples d and child_present when the word is valid.
import dtree_pkg::*;

module dtree_node_eval #(
    parameter int F   = 3,
    parameter int FB  = 8,
    parameter int CB  = 4,
    parameter int BB  = 10,
    parameter int NW  = node_width(F, CB, BB),
    parameter int ACC = acc_width(F, FB, CB, BB)
) (
    input  logic [NW-1:0]   node,
    input  logic [F*FB-1:0] features,
    output logic            d,
    output logic [1:0]      child_present
);

    localparam int ULSB = unit_lsb(F, CB, BB);
    localparam int CLSB = child_lsb(F, CB, BB);

    logic [F-1:0]          unit;
    logic signed [ACC-1:0] sum;
    logic signed [ACC-1:0] feat_ext;
    logic signed [ACC-1:0] coeff_ext;
    int                    unit_idx;
    int                    j;
    logic                  unused_reserved;

    assign unit            = node[ULSB +: F];
    assign unused_reserved = node[NW-1];

    // With no unit bit set, unit_idx = F so nothing is skipped and the last
    // feature has no coefficient field.
    always_comb begin
        unit_idx  = F;
        sum       = ACC'($signed(node[BB-1:0]));
        feat_ext  = '0;
        coeff_ext = '0;
        j         = 0;
        for (int i = F - 1; i >= 0; i--) begin
            if (unit[i]) begin
                unit_idx = i;
            end
        end
        for (int i = 0; i < F; i++) begin
            feat_ext = ACC'($signed(features[i*FB +: FB]));
            if (i == unit_idx) begin
                sum = sum + feat_ext;
            end else begin
                j = (i > unit_idx) ? i - 1 : i;
                if (j < F - 1) begin
                    coeff_ext = ACC'($signed(node[BB + j*CB +: CB]));
                    sum       = sum + feat_ext * coeff_ext;
                end
            end
        end
    end

    assign d             = ~sum[ACC-1];
    assign child_present = node[CLSB +: 2];

endmodule

// File: rtl/dtree_traverse.sv
// Heap-addressed decision-tree walker: one node per FETCH/EVAL pair, label held in DONE.
// Label valid 1+2n cycles after accept for an n-node path; busy (in_ready=0) until label taken.
import dtree_pkg::*;

module dtree_traverse #(
    parameter int FEATURES          = 3,
    parameter int FEATURE_BIT_DEPTH = 8,
    parameter int COEFF_BIT_DEPTH   = 4,
    parameter int BIAS_BIT_DEPTH    = 10,
    parameter int WORDS             = 8,
    parameter int AW                = $clog2(WORDS),
    parameter int NODE_WIDTH        = node_width(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] in_features,
    output logic                                  mem_ce,
    output logic                                  mem_we,
    output logic [AW-1:0]                         mem_a,
    output logic [NODE_WIDTH-1:0]                 mem_d,
    input  logic [NODE_WIDTH-1:0]                 mem_q,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [AW:0]                           out_label
);

    localparam int FW  = FEATURES * FEATURE_BIT_DEPTH;
    localparam int ACC = acc_width(FEATURES, FEATURE_BIT_DEPTH, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [FW-1:0] feat_q, feat_d;
    logic [AW:0]   label_q, label_d;

    logic          node_d;
    logic [1:0]    child_present;
    logic [AW+1:0] child_addr;
    logic          child_ok;

    dtree_node_eval #(
        .F   (FEATURES),
        .FB  (FEATURE_BIT_DEPTH),
        .CB  (COEFF_BIT_DEPTH),
        .BB  (BIAS_BIT_DEPTH),
        .NW  (NODE_WIDTH),
        .ACC (ACC)
    ) u_eval (
        .node          (mem_q),
        .features      (feat_q),
        .d             (node_d),
        .child_present (child_present)
    );

    // Child address computed two bits wider so 2a+2 past the last word is detectable.
    assign child_addr = {1'b0, addr_q, 1'b0} + (node_d ? (AW+2)'(2) : (AW+2)'(1));
    assign child_ok   = child_present[node_d] && (child_addr < (AW+2)'(WORDS));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        feat_d  = feat_q;
        label_d = label_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    feat_d  = in_features;
                end
            end
            ST_FETCH: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (child_ok) begin
                    addr_d  = child_addr[AW-1:0];
                    state_d = ST_FETCH;
                end else begin
                    label_d = {addr_q, node_d};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            feat_q  <= '0;
            label_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            feat_q  <= feat_d;
            label_q <= label_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign mem_ce    = (state_q == ST_FETCH);
    assign mem_a     = addr_q;
    assign mem_we    = 1'b0;
    assign mem_d     = '0;
    assign out_label = label_q;

endmodule

// File: tb/tb_dtree_traverse.sv
// Directed vector table plus hand-written backpressure, early-ready and reset sequences.
module tb_dtree_traverse;

    localparam int NW = 24;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [23:0]   in_features = '0;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [NW-1:0] mem_d;
    logic [NW-1:0] mem_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   out_label;

    logic [NW-1:0] mem [8];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) mem_q <= mem[mem_a];
    end

    dtree_traverse dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_features (in_features),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_label   (out_label)
    );

    typedef struct {
        string               name;
        logic [7:0][NW-1:0]  nodes;
        logic [23:0]         feats;
        logic [3:0]          label;
        int                  n;
        logic [3:0][2:0]     path;
    } vec_t;

    vec_t tv[10];

    function automatic logic [NW-1:0] nw(input logic [1:0] ch, input logic [2:0] un,
                                         input int c1, input int c0, input int b);
        logic [31:0] c1v, c0v, bv;
        c1v = c1;
        c0v = c0;
        bv  = b;
        return {1'b0, ch, un, c1v[3:0], c0v[3:0], bv[9:0]};
    endfunction

    function automatic logic [23:0] fx(input int x0, input int x1, input int x2);
        logic [31:0] a, b, c;
        a = x0;
        b = x1;
        c = x2;
        return {c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [11:0] mkp(input int a0, input int a1, input int a2);
        logic [31:0] p0, p1, p2;
        p0 = a0;
        p1 = a1;
        p2 = a2;
        return {3'd0, p2[2:0], p1[2:0], p0[2:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int idx);
        for (int i = 0; i < 8; i++) mem[i] = tv[idx].nodes[i];
    endtask

    // Accept one vector, follow it to out_valid, check latency, path and label, then take the label.
    task automatic run_one(input int idx);
        int k;
        int np;
        logic [7:0][2:0] got;
        got = '0;
        load(idx);
        @(negedge clk);
        check({tv[idx].name, " in_ready"}, 32'(in_ready), 32'd1);
        in_features = tv[idx].feats;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k  = 1;
        np = 0;
        while (!out_valid && k < 40) begin
            if (mem_ce) begin
                if (np < 8) got[np] = mem_a;
                np++;
            end
            @(negedge clk);
            k++;
        end
        check({tv[idx].name, " latency"}, 32'(k), 32'(2 * tv[idx].n + 1));
        check({tv[idx].name, " label"}, 32'(out_label), 32'(tv[idx].label));
        check({tv[idx].name, " fetches"}, 32'(np), 32'(tv[idx].n));
        for (int i = 0; i < tv[idx].n; i++)
            check({tv[idx].name, " mem_a"}, 32'(got[i]), 32'(tv[idx].path[i]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tv[idx].name, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic wait_valid(input string nm, input int exp_k);
        int k;
        k = 1;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, 32'(k), 32'(exp_k));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 10; i++) begin
            tv[i].nodes = '0;
            tv[i].path  = '0;
        end
        tv[0].name = "leaf_d1";    tv[0].nodes[0] = nw(2'b00, 3'b001, 0, 0, -10);
        tv[0].feats = fx(10, 0, 0);      tv[0].label = 4'b0001; tv[0].n = 1; tv[0].path = mkp(0, 0, 0);
        tv[1].name = "leaf_d0";    tv[1].nodes[0] = nw(2'b00, 3'b001, 0, 0, -10);
        tv[1].feats = fx(9, 0, 0);       tv[1].label = 4'b0000; tv[1].n = 1; tv[1].path = mkp(0, 0, 0);
        tv[2].name = "two_level";  tv[2].nodes[0] = nw(2'b10, 3'b001, 0, 0, -10);
        tv[2].nodes[2] = nw(2'b00, 3'b010, 0, 0, 0);
        tv[2].feats = fx(20, -1, 0);     tv[2].label = 4'b0100; tv[2].n = 2; tv[2].path = mkp(0, 2, 0);
        tv[3].name = "extremes";   tv[3].nodes[0] = nw(2'b00, 3'b001, -8, -8, -512);
        tv[3].feats = fx(-128, -128, -128); tv[3].label = 4'b0001; tv[3].n = 1; tv[3].path = mkp(0, 0, 0);
        tv[4].name = "deep_oob";   tv[4].nodes[0] = nw(2'b01, 3'b001, 0, 0, 0);
        tv[4].nodes[1] = nw(2'b01, 3'b001, 0, 0, 0);
        tv[4].nodes[3] = nw(2'b10, 3'b001, 0, 0, 100);
        tv[4].feats = fx(-5, 0, 0);      tv[4].label = 4'b0111; tv[4].n = 3; tv[4].path = mkp(0, 1, 3);
        tv[5].name = "coef_neg";   tv[5].nodes[0] = nw(2'b00, 3'b010, -3, 2, 0);
        tv[5].feats = fx(5, 1, 4);       tv[5].label = 4'b0000; tv[5].n = 1; tv[5].path = mkp(0, 0, 0);
        tv[6].name = "coef_zero";  tv[6].nodes[0] = nw(2'b00, 3'b010, -3, 2, 0);
        tv[6].feats = fx(5, 2, 4);       tv[6].label = 4'b0001; tv[6].n = 1; tv[6].path = mkp(0, 0, 0);
        tv[7].name = "multi_hot";  tv[7].nodes[0] = nw(2'b00, 3'b110, 0, 0, 0) | 24'h800000;
        tv[7].feats = fx(-50, 3, -100);  tv[7].label = 4'b0001; tv[7].n = 1; tv[7].path = mkp(0, 0, 0);
        tv[8].name = "unit_x2";    tv[8].nodes[0] = nw(2'b11, 3'b100, -1, 1, 0);
        tv[8].nodes[1] = nw(2'b00, 3'b001, 0, 0, 0);
        tv[8].feats = fx(3, 10, -8);     tv[8].label = 4'b0011; tv[8].n = 2; tv[8].path = mkp(0, 1, 0);
        tv[9].name = "right_absent"; tv[9].nodes[0] = nw(2'b01, 3'b001, 0, 0, 0);
        tv[9].feats = fx(1, 0, 0);       tv[9].label = 4'b0001; tv[9].n = 1; tv[9].path = mkp(0, 0, 0);

        // Reset state
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_label", 32'(out_label), 32'd0);
        check("rst mem_ce", 32'(mem_ce), 32'd0);
        check("rst mem_a", 32'(mem_a), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_one(i);

        // Backpressure in DONE with in_valid held high throughout
        load(2);
        @(negedge clk);
        in_features = tv[2].feats;
        in_valid    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp in_ready busy", 32'(in_ready), 32'd0);
        wait_valid("bp first", 4);
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp label held", 32'(out_label), 32'h4);
            check("bp in_ready low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp released", 32'(out_valid), 32'd0);
        check("bp idle", 32'(in_ready), 32'd1);
        in_features = fx(-20, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp second", 3);
        check("bp second label", 32'(out_label), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // out_ready already high on entering DONE, in_valid high in the DONE cycle
        load(0);
        out_ready   = 1'b1;
        in_features = tv[0].feats;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("early", 3);
        check("early label", 32'(out_label), 32'h1);
        in_valid = 1'b1;
        @(negedge clk);
        check("early one-cycle valid", 32'(out_valid), 32'd0);
        check("early no accept in done", 32'(in_ready), 32'd1);
        check("early no fetch", 32'(mem_ce), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("early next fetch", 32'(mem_ce), 32'd1);
        wait_valid("early second", 3);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset asserted during EVAL of node 2
        load(2);
        in_features = tv[2].feats;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid eval addr", 32'(mem_a), 32'd2);
        reset = 1'b0;
        #1;
        check("mid rst mem_ce", 32'(mem_ce), 32'd0);
        check("mid rst mem_a", 32'(mem_a), 32'd0);
        check("mid rst label", 32'(out_label), 32'd0);
        @(negedge clk);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge clk);
        check("mid rst no label", 32'(out_valid), 32'd0);
        run_one(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
